estacao_reserva: RTL and testbench

Reservation station feeding one arithmetic unit (add/sub/address calc) of the Tomasulo core. Holds up to ENTRIES issued instructions, captures missing operands by snooping the Common Data Bus (CDB), and dispatches the oldest-by-index ready entry to the unit through the start / busy / confirmacao handshake. Each entry owns a fixed 3-bit tag, which travels to the unit as ID_out and identifies the producer on the CDB.

---
 rtl/estacao_reserva_pkg.sv | 21 ++
 rtl/estacao_entrada.sv | 81 ++++++++
 rtl/estacao_reserva.sv | 172 +++++++++++++++++
 tb/tb_estacao_reserva.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/estacao_reserva_pkg.sv
// rtl/estacao_reserva_pkg.sv - shared widths, opcodes and FSM states for the reservation station
package estacao_reserva_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = 3'd0;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_ST  = 3'b100;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } estado_t;

endpackage

// File: rtl/estacao_entrada.sv
// rtl/estacao_entrada.sv - one reservation entry: issue write, CDB bypass and CDB snoop
module estacao_entrada
  import estacao_reserva_pkg::*;
(
  input  logic              CLK,
  input  logic              CLR,
  input  logic              wr_en,
  input  logic [2:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              disp_en,
  input  logic              free_en,
  output logic              busy,
  output logic              ready,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk,
  output logic [2:0]        op
);

  logic [TAG_W-1:0] qj;
  logic [TAG_W-1:0] qk;
  logic             dispatched;
  logic             cdb_live;
  logic             byp_j;
  logic             byp_k;
  logic             snp_j;
  logic             snp_k;

  // CDB matches: bypass compares against the incoming issue, snoop against stored tags
  always_comb begin
    cdb_live = cdb_valid && (cdb_tag != TAG_NONE);
    byp_j    = cdb_live && (cdb_tag == issue_qj);
    byp_k    = cdb_live && (cdb_tag == issue_qk);
    snp_j    = cdb_live && busy && (qj == cdb_tag);
    snp_k    = cdb_live && busy && (qk == cdb_tag);
  end

  // Entry registers; an issue only ever targets a free entry, so it excludes snoop/dispatch/free
  always_ff @(posedge CLK) begin
    if (CLR) begin
      busy       <= 1'b0;
      dispatched <= 1'b0;
      op         <= 3'd0;
      vj         <= '0;
      vk         <= '0;
      qj         <= TAG_NONE;
      qk         <= TAG_NONE;
    end else if (wr_en) begin
      busy       <= 1'b1;
      dispatched <= 1'b0;
      op         <= issue_op;
      vj         <= byp_j ? cdb_data : issue_vj;
      qj         <= byp_j ? TAG_NONE : issue_qj;
      vk         <= byp_k ? cdb_data : issue_vk;
      qk         <= byp_k ? TAG_NONE : issue_qk;
    end else begin
      if (snp_j) begin
        vj <= cdb_data;
        qj <= TAG_NONE;
      end
      if (snp_k) begin
        vk <= cdb_data;
        qk <= TAG_NONE;
      end
      if (disp_en) begin
        dispatched <= 1'b1;
      end
      if (free_en) begin
        busy <= 1'b0;
      end
    end
  end

  assign ready = busy && !dispatched && (qj == TAG_NONE) && (qk == TAG_NONE);

endmodule

// File: rtl/estacao_reserva.sv
// rtl/estacao_reserva.sv - reservation station top: entries, priority encoders, dispatch FSM
module estacao_reserva
  import estacao_reserva_pkg::*;
#(
  parameter int ENTRIES  = 3,
  parameter int TAG_BASE = 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              issue_valid,
  input  logic [2:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              start,
  output logic [TAG_W-1:0]  ID_out,
  output logic [DATA_W-1:0] Dado1,
  output logic [DATA_W-1:0] Dado2,
  output logic [2:0]        op,
  input  logic              ua_busy,
  input  logic              confirmacao
);

  logic [ENTRIES-1:0] e_busy;
  logic [ENTRIES-1:0] e_ready;
  logic [ENTRIES-1:0] wr_vec;
  logic [ENTRIES-1:0] disp_vec;
  logic [ENTRIES-1:0] free_vec;
  logic [DATA_W-1:0]  e_vj [ENTRIES];
  logic [DATA_W-1:0]  e_vk [ENTRIES];
  logic [2:0]         e_op [ENTRIES];

  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic               any_free;
  logic               any_ready;
  logic [DATA_W-1:0]  rdy_vj;
  logic [DATA_W-1:0]  rdy_vk;
  logic [2:0]         rdy_op;

  estado_t estado;
  estado_t prox;
  logic    dispatch_go;
  logic    free_go;

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    estacao_entrada u_ent (
      .CLK       (CLK),
      .CLR       (CLR),
      .wr_en     (wr_vec[i]),
      .issue_op  (issue_op),
      .issue_vj  (issue_vj),
      .issue_qj  (issue_qj),
      .issue_vk  (issue_vk),
      .issue_qk  (issue_qk),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .disp_en   (disp_vec[i]),
      .free_en   (free_vec[i]),
      .busy      (e_busy[i]),
      .ready     (e_ready[i]),
      .vj        (e_vj[i]),
      .vk        (e_vk[i]),
      .op        (e_op[i])
    );
  end

  // Lowest-index free slot and lowest-index ready entry, plus the ready entry's fields
  always_comb begin
    any_free  = 1'b0;
    free_idx  = '0;
    any_ready = 1'b0;
    rdy_idx   = '0;
    rdy_vj    = '0;
    rdy_vk    = '0;
    rdy_op    = 3'd0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!e_busy[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
      if (e_ready[i]) begin
        any_ready = 1'b1;
        rdy_idx   = IDX_W'(i);
        rdy_vj    = e_vj[i];
        rdy_vk    = e_vk[i];
        rdy_op    = e_op[i];
      end
    end
  end

  assign issue_ready = any_free;
  assign issue_tag   = TAG_W'(TAG_BASE) + free_idx;

  // One-hot strobes to the entries for issue write, dispatch mark and release
  always_comb begin
    wr_vec   = '0;
    disp_vec = '0;
    free_vec = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      wr_vec[i]   = issue_valid && any_free && (free_idx == IDX_W'(i));
      disp_vec[i] = dispatch_go && (rdy_idx == IDX_W'(i));
      free_vec[i] = free_go && (sel_idx == IDX_W'(i));
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      estado <= IDLE;
    end else begin
      estado <= prox;
    end
  end

  // Next state: dispatch from IDLE, one SEND cycle, then hold operands until the unit confirms
  always_comb begin
    prox        = estado;
    dispatch_go = 1'b0;
    free_go     = 1'b0;
    case (estado)
      IDLE: begin
        if (!ua_busy && any_ready) begin
          dispatch_go = 1'b1;
          prox        = SEND;
        end
      end
      SEND: begin
        prox = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!ua_busy && confirmacao) begin
          free_go = 1'b1;
          prox    = IDLE;
        end
      end
      default: begin
        prox = IDLE;
      end
    endcase
  end

  // Registered unit interface; operands only change on a new dispatch so they stay stable
  always_ff @(posedge CLK) begin
    if (CLR) begin
      start   <= 1'b0;
      ID_out  <= TAG_NONE;
      Dado1   <= '0;
      Dado2   <= '0;
      op      <= 3'd0;
      sel_idx <= '0;
    end else begin
      start <= dispatch_go;
      if (dispatch_go) begin
        ID_out  <= TAG_W'(TAG_BASE) + rdy_idx;
        Dado1   <= rdy_vj;
        Dado2   <= rdy_vk;
        op      <= rdy_op;
        sel_idx <= rdy_idx;
      end
    end
  end

endmodule

// File: tb/tb_estacao_reserva.sv
// tb/tb_estacao_reserva.sv - self-checking bench for estacao_reserva
module tb_estacao_reserva;

  localparam int ENTRIES  = 3;
  localparam int TAG_BASE = 1;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_op = 3'd0;
  logic [15:0] issue_vj = 16'd0;
  logic [2:0]  issue_qj = 3'd0;
  logic [15:0] issue_vk = 16'd0;
  logic [2:0]  issue_qk = 3'd0;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = 3'd0;
  logic [15:0] cdb_data = 16'd0;
  logic        start;
  logic [2:0]  ID_out;
  logic [15:0] Dado1;
  logic [15:0] Dado2;
  logic [2:0]  op;
  logic        ua_busy = 1'b0;
  logic        confirmacao = 1'b0;

  always #5 CLK = ~CLK;

  estacao_reserva #(.ENTRIES(ENTRIES), .TAG_BASE(TAG_BASE)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_qj    (issue_qj),
    .issue_vk    (issue_vk),
    .issue_qk    (issue_qk),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .start       (start),
    .ID_out      (ID_out),
    .Dado1       (Dado1),
    .Dado2       (Dado2),
    .op          (op),
    .ua_busy     (ua_busy),
    .confirmacao (confirmacao)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Arithmetic unit: takes start, busy for one cycle, then raises confirmacao until next start
  always @(posedge CLK) begin
    if (CLR) begin
      ua_busy     <= 1'b0;
      confirmacao <= 1'b0;
    end else if (start) begin
      ua_busy     <= 1'b1;
      confirmacao <= 1'b0;
    end else if (ua_busy) begin
      ua_busy     <= 1'b0;
      confirmacao <= 1'b1;
    end
  end

  // Station model: entry table, one operation in flight at a time
  int  cyc_n = 0;
  bit  started = 0;
  bit  m_busy [ENTRIES];
  bit  m_disp [ENTRIES];
  int  m_op [ENTRIES];
  int  m_vj [ENTRIES];
  int  m_qj [ENTRIES];
  int  m_vk [ENTRIES];
  int  m_qk [ENTRIES];
  bit  m_inflight = 0;
  int  m_phase = 0;
  int  m_idx = 0;
  int  e_start = 0, e_id = 0, e_d1 = 0, e_d2 = 0, e_op = 0;

  always @(posedge CLK) begin : model_p
    int pick;
    int slot;
    cyc_n++;
    if (CLR) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_busy[i] = 0;
        m_disp[i] = 0;
      end
      m_inflight = 0;
      m_phase = 0;
      e_start = 0; e_id = 0; e_d1 = 0; e_d2 = 0; e_op = 0;
      started = 1;
    end else begin
      pick = -1;
      slot = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (m_busy[i] && !m_disp[i] && m_qj[i] == 0 && m_qk[i] == 0) pick = i;
        if (!m_busy[i]) slot = i;
      end
      e_start = 0;
      if (m_inflight) begin
        if (m_phase == 0) m_phase = 1;
        else if (!ua_busy && confirmacao) begin
          m_busy[m_idx] = 0;
          m_inflight = 0;
        end
      end else if (!ua_busy && pick >= 0) begin
        e_start = 1;
        e_id = TAG_BASE + pick;
        e_d1 = m_vj[pick];
        e_d2 = m_vk[pick];
        e_op = m_op[pick];
        m_disp[pick] = 1;
        m_inflight = 1;
        m_phase = 0;
        m_idx = pick;
      end
      if (cdb_valid && cdb_tag != 0) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (m_busy[i] && m_qj[i] == int'(cdb_tag)) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
          if (m_busy[i] && m_qk[i] == int'(cdb_tag)) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
        end
      end
      if (issue_valid && slot >= 0) begin
        m_busy[slot] = 1;
        m_disp[slot] = 0;
        m_op[slot] = issue_op;
        if (cdb_valid && cdb_tag != 0 && cdb_tag == issue_qj) begin
          m_vj[slot] = cdb_data; m_qj[slot] = 0;
        end else begin
          m_vj[slot] = issue_vj; m_qj[slot] = issue_qj;
        end
        if (cdb_valid && cdb_tag != 0 && cdb_tag == issue_qk) begin
          m_vk[slot] = cdb_data; m_qk[slot] = 0;
        end else begin
          m_vk[slot] = issue_vk; m_qk[slot] = issue_qk;
        end
      end
    end
  end

  // Dispatch log for the directed checks
  int st_cyc [$];
  int st_id  [$];
  int st_d1  [$];
  int st_d2  [$];
  int st_op  [$];

  // Every-cycle comparison of all outputs against the model, away from the rising edge
  always @(negedge CLK) begin : cmp_p
    int lf;
    if (started) begin
      lf = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) if (!m_busy[i]) lf = i;
      chk("start", start, e_start);
      chk("ID_out", ID_out, e_id);
      chk("Dado1", Dado1, e_d1);
      chk("Dado2", Dado2, e_d2);
      chk("op", op, e_op);
      chk("issue_ready", issue_ready, (lf >= 0) ? 1 : 0);
      if (lf >= 0) chk("issue_tag", issue_tag, TAG_BASE + lf);
      if (start) begin
        st_cyc.push_back(cyc_n);
        st_id.push_back(ID_out);
        st_d1.push_back(Dado1);
        st_d2.push_back(Dado2);
        st_op.push_back(op);
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_issue(input int o, input int vj, input int qj, input int vk, input int qk);
    issue_valid = 1'b1;
    issue_op = 3'(o);
    issue_vj = 16'(vj);
    issue_qj = 3'(qj);
    issue_vk = 16'(vk);
    issue_qk = 3'(qk);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (st_id.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, (st_id.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic chk_start(input int k, input int id, input int d1, input int d2, input int o,
                           input int cyc);
    if (k < st_id.size()) begin
      chk("disp_id", st_id[k], id);
      chk("disp_d1", st_d1[k], d1);
      chk("disp_d2", st_d2[k], d2);
      chk("disp_op", st_op[k], o);
      chk("disp_cycle", st_cyc[k], cyc);
    end else begin
      chk("disp_missing", st_id.size(), k + 1);
    end
  endtask

  int base;
  int n0;

  initial begin
    // 1: reset
    CLR = 1'b1;
    steps(2);
    CLR = 1'b0;
    chk("rst_start", start, 0);
    chk("rst_ID_out", ID_out, 0);
    chk("rst_Dado1", Dado1, 0);
    chk("rst_Dado2", Dado2, 0);
    chk("rst_op", op, 0);
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_issue_tag", issue_tag, 1);

    // 2: both operands ready
    base = st_id.size();
    n0 = cyc_n + 1;
    do_issue(1, 5, 0, 7, 0);
    wait_starts(base + 1, 10, "t2_dispatch");
    chk_start(base, 1, 5, 7, 1, n0 + 1);
    steps(6);
    chk("t2_free_tag", issue_tag, 1);
    chk("t2_free_ready", issue_ready, 1);

    // 3: operand j waits for the CDB
    base = st_id.size();
    do_issue(2, 0, 3, 10, 0);
    steps(3);
    chk("t3_no_start", st_id.size(), base);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'd20;
    n0 = cyc_n + 1;
    step();
    cdb_valid = 1'b0;
    wait_starts(base + 1, 10, "t3_dispatch");
    chk_start(base, 1, 20, 10, 2, n0 + 1);
    steps(6);

    // 4: issue-time bypass of operand k
    base = st_id.size();
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 16'd9;
    n0 = cyc_n + 1;
    do_issue(1, 4, 0, 0, 5);
    cdb_valid = 1'b0;
    wait_starts(base + 1, 10, "t4_dispatch");
    chk_start(base, 1, 4, 9, 1, n0 + 1);
    steps(6);

    // 5: fill the station, ignored fourth issue, ordered back-to-back dispatch
    base = st_id.size();
    do_issue(3, 0, 6, 1, 0);
    do_issue(3, 0, 6, 2, 0);
    do_issue(4, 0, 6, 3, 0);
    chk("t5_full", issue_ready, 0);
    do_issue(1, 50, 0, 60, 0);
    steps(2);
    chk("t5_no_start", st_id.size(), base);
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'd100;
    n0 = cyc_n + 1;
    step();
    cdb_valid = 1'b0;
    wait_starts(base + 3, 30, "t5_dispatch");
    chk_start(base, 1, 100, 1, 3, n0 + 1);
    chk_start(base + 1, 2, 100, 2, 3, n0 + 5);
    chk_start(base + 2, 3, 100, 3, 4, n0 + 9);
    steps(6);
    chk("t5_fourth_ignored", st_id.size(), base + 3);
    chk("t5_empty", issue_ready, 1);

    // 6: reset while waiting for the unit with two entries busy
    base = st_id.size();
    do_issue(1, 1, 0, 2, 0);
    do_issue(2, 8, 0, 3, 0);
    step();
    chk("t6_one_dispatch", st_id.size(), base + 1);
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    chk("t6_start", start, 0);
    chk("t6_issue_ready", issue_ready, 1);
    chk("t6_issue_tag", issue_tag, 1);
    steps(8);
    chk("t6_no_dispatch", st_id.size(), base + 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
